// File: rtl/spike_vote_classifier.sv
// Spike-vote readout: integrates signed per-class spike counts over a fixed
// window, then scans the counters and reports the highest-scoring class.
module spike_vote_classifier #(
  parameter int NUM_CLASSES   = 10,
  parameter int WINDOW_CYCLES = 256,
  parameter int COUNT_WIDTH   = 8,
  parameter int IDX_WIDTH     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_CLASSES-1:0] pos_spikes,
  input  logic [NUM_CLASSES-1:0] neg_spikes,
  output logic                   busy,
  output logic                   result_valid,
  output logic [IDX_WIDTH-1:0]   class_out,
  output logic [COUNT_WIDTH-1:0] score_out
);

  localparam int TIMER_W = $clog2(WINDOW_CYCLES + 1);
  localparam logic [TIMER_W-1:0]   TIMER_LOAD = TIMER_W'(WINDOW_CYCLES);
  localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(1);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST   = IDX_WIDTH'(NUM_CLASSES - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_ONE    = IDX_WIDTH'(1);
  localparam logic signed [COUNT_WIDTH-1:0] CNT_MAX = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
  localparam logic signed [COUNT_WIDTH-1:0] CNT_MIN = {1'b1, {(COUNT_WIDTH-1){1'b0}}};
  localparam logic signed [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                                    state_reg;
  logic [TIMER_W-1:0]                        timer_reg;
  logic [IDX_WIDTH-1:0]                      scan_idx_reg;
  logic [IDX_WIDTH-1:0]                      best_idx_reg;
  logic signed [COUNT_WIDTH-1:0]             best_score_reg;
  logic [NUM_CLASSES-1:0][COUNT_WIDTH-1:0]   count_reg;
  logic [NUM_CLASSES-1:0][COUNT_WIDTH-1:0]   count_next;
  logic                                      busy_reg;
  logic                                      result_valid_reg;
  logic [IDX_WIDTH-1:0]                      class_out_reg;
  logic [COUNT_WIDTH-1:0]                    score_out_reg;

  logic signed [COUNT_WIDTH-1:0]             scan_count;
  logic                                      scan_take;

  // Per-class saturating accumulate; coincident pos/neg spikes cancel.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_class
      logic signed [COUNT_WIDTH-1:0] cur;
      logic                          inc;
      logic                          dec;

      assign cur = count_reg[gi];
      assign inc = pos_spikes[gi] && !neg_spikes[gi] && (cur != CNT_MAX);
      assign dec = neg_spikes[gi] && !pos_spikes[gi] && (cur != CNT_MIN);
      assign count_next[gi] = inc ? (cur + CNT_ONE) :
                              dec ? (cur - CNT_ONE) : cur;
    end
  endgenerate

  // Class 0 always seeds the best; later classes need a strictly larger count,
  // so ties resolve to the lowest index.
  assign scan_count = count_reg[scan_idx_reg];
  assign scan_take  = (scan_idx_reg == '0) || (scan_count > best_score_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      timer_reg        <= '0;
      scan_idx_reg     <= '0;
      best_idx_reg     <= '0;
      best_score_reg   <= '0;
      count_reg        <= '0;
      busy_reg         <= 1'b0;
      result_valid_reg <= 1'b0;
      class_out_reg    <= '0;
      score_out_reg    <= '0;
    end else begin
      result_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          busy_reg <= start;
          if (start) begin
            count_reg    <= '0;
            timer_reg    <= TIMER_LOAD;
            scan_idx_reg <= '0;
            state_reg    <= ACCUM;
          end
        end

        ACCUM: begin
          busy_reg  <= 1'b1;
          count_reg <= count_next;
          timer_reg <= timer_reg - TIMER_LAST;
          if (timer_reg == TIMER_LAST) begin
            scan_idx_reg <= '0;
            state_reg    <= SCAN;
          end
        end

        SCAN: begin
          busy_reg <= 1'b1;
          if (scan_take) begin
            best_score_reg <= scan_count;
            best_idx_reg   <= scan_idx_reg;
          end
          if (scan_idx_reg == IDX_LAST) begin
            state_reg <= DONE;
          end else begin
            scan_idx_reg <= scan_idx_reg + IDX_ONE;
          end
        end

        DONE: begin
          // busy stays high through the result cycle; it drops on the next
          // IDLE edge unless a new start is accepted there.
          busy_reg         <= 1'b1;
          result_valid_reg <= 1'b1;
          class_out_reg    <= best_idx_reg;
          score_out_reg    <= best_score_reg;
          state_reg        <= IDLE;
        end

        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_reg;
  assign result_valid = result_valid_reg;
  assign class_out    = class_out_reg;
  assign score_out    = score_out_reg;

endmodule

// File: tb/tb_spike_vote_classifier.sv
// Bench for spike_vote_classifier: table of spike-count vectors driven through a
// 16-cycle window on an 8-bit and a 4-bit counter instance, results scoreboarded.
module tb_spike_vote_classifier;

  localparam int NC  = 10;
  localparam int W   = 16;
  localparam int CW  = 8;
  localparam int CWS = 4;
  localparam int IW  = 4;
  localparam int LAT = W + NC + 1;
  localparam int NV  = 8;
  localparam logic [NC-1:0] BIT6 = 10'b0001000000;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [NC-1:0]  pos_spikes;
  logic [NC-1:0]  neg_spikes;
  logic           busy, result_valid;
  logic [IW-1:0]  class_out;
  logic [CW-1:0]  score_out;
  logic           busy_s, rv_s;
  logic [IW-1:0]  class_s;
  logic [CWS-1:0] score_s;

  spike_vote_classifier #(
    .NUM_CLASSES(NC), .WINDOW_CYCLES(W), .COUNT_WIDTH(CW), .IDX_WIDTH(IW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .pos_spikes(pos_spikes), .neg_spikes(neg_spikes),
    .busy(busy), .result_valid(result_valid),
    .class_out(class_out), .score_out(score_out)
  );

  spike_vote_classifier #(
    .NUM_CLASSES(NC), .WINDOW_CYCLES(W), .COUNT_WIDTH(CWS), .IDX_WIDTH(IW)
  ) dut_sat (
    .clk(clk), .reset(reset), .start(start),
    .pos_spikes(pos_spikes), .neg_spikes(neg_spikes),
    .busy(busy_s), .result_valid(rv_s),
    .class_out(class_s), .score_out(score_s)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [NC-1:0][4:0]     pos_cnt;
    logic [NC-1:0][4:0]     neg_cnt;
    logic [3:0]             exp_class;
    logic signed [7:0]      exp_score;
  } vec_t;

  typedef struct {
    int cls;
    int score;
    int scls;
    int sscore;
    int cyc;
  } exp_t;

  vec_t tbl [NV];
  exp_t sb [$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  logic prev_rv = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference for the 4-bit instance: net count clamps to [-8,7], first maximum wins.
  task automatic sat_model(input vec_t v, output int cls, output int sc);
    int val;
    cls = 0;
    sc  = 0;
    for (int i = 0; i < NC; i++) begin
      val = int'(v.pos_cnt[i]) - int'(v.neg_cnt[i]);
      if (val > 7) val = 7;
      if (val < -8) val = -8;
      if (i == 0 || val > sc) begin
        cls = i;
        sc  = val;
      end
    end
  endtask

  // Scoreboard consumer: one line per delivered result.
  always @(negedge clk) begin
    if (result_valid || rv_s) begin
      check("rv_instances_agree", int'(rv_s), int'(result_valid));
      check("rv_single_pulse", int'(prev_rv), 0);
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_result: class %0d score %0d at cycle %0d, none expected",
                 class_out, $signed(score_out), cyc);
      end else begin
        mon_e = sb.pop_front();
        $display("result cycle %0d: class %0d score %0d | sat class %0d score %0d",
                 cyc, class_out, $signed(score_out), class_s, $signed(score_s));
        check("latency", cyc, mon_e.cyc);
        check("class_out", int'(class_out), mon_e.cls);
        check("score_out", int'($signed(score_out)), mon_e.score);
        check("sat_class_out", int'(class_s), mon_e.scls);
        check("sat_score_out", int'($signed(score_s)), mon_e.sscore);
      end
    end
    prev_rv = result_valid;
  end

  task automatic push_exp(input vec_t v, input int at_cyc);
    exp_t e;
    e.cls   = int'(v.exp_class);
    e.score = int'(v.exp_score);
    sat_model(v, e.scls, e.sscore);
    e.cyc   = at_cyc;
    sb.push_back(e);
  endtask

  // One full classification; start-edge spikes carry junk that must not count.
  task automatic run_vec(input vec_t v);
    logic [NC-1:0] p, n;
    int c0;
    @(negedge clk);
    push_exp(v, cyc + 1 + LAT);
    start      = 1'b1;
    pos_spikes = NC'($urandom) | BIT6;
    neg_spikes = NC'($urandom) & ~BIT6;
    @(negedge clk);
    c0 = cyc;
    check("busy_after_start", int'(busy), 1);
    start = 1'b0;
    for (int k = 1; k <= W; k++) begin
      for (int i = 0; i < NC; i++) begin
        p[i] = (k <= int'(v.pos_cnt[i]));
        n[i] = (k <= int'(v.neg_cnt[i]));
      end
      pos_spikes = p;
      neg_spikes = n;
      @(negedge clk);
    end
    while (cyc < c0 + LAT) begin
      pos_spikes = NC'($urandom);
      neg_spikes = NC'($urandom);
      @(negedge clk);
    end
    check("busy_in_done", int'(busy), 1);
    pos_spikes = '0;
    neg_spikes = '0;
    @(negedge clk);
    check("busy_low_after_done", int'(busy), 0);
    check("rv_low_after_done", int'(result_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int j = 0; j < NV; j++) tbl[j] = '0;
    tbl[0].pos_cnt[3] = 5'd16; tbl[0].pos_cnt[7] = 5'd8;
    tbl[0].exp_class = 4'd3;  tbl[0].exp_score = 8'sd16;
    tbl[1].pos_cnt[2] = 5'd4;  tbl[1].pos_cnt[5] = 5'd4;
    tbl[1].exp_class = 4'd2;  tbl[1].exp_score = 8'sd4;
    for (int i = 0; i < NC; i++) tbl[2].neg_cnt[i] = 5'd6;
    tbl[2].neg_cnt[4] = 5'd5;
    tbl[2].exp_class = 4'd4;  tbl[2].exp_score = -8'sd5;
    tbl[3].pos_cnt[1] = 5'd16; tbl[3].neg_cnt[1] = 5'd16;
    tbl[3].exp_class = 4'd0;  tbl[3].exp_score = 8'sd0;
    for (int i = 0; i < NC - 1; i++) tbl[4].neg_cnt[i] = 5'd16;
    tbl[4].pos_cnt[9] = 5'd16;
    tbl[4].exp_class = 4'd9;  tbl[4].exp_score = 8'sd16;
    tbl[5].exp_class = 4'd0;  tbl[5].exp_score = 8'sd0;
    tbl[6].pos_cnt[0] = 5'd3;  tbl[6].pos_cnt[6] = 5'd10; tbl[6].neg_cnt[6] = 5'd2;
    tbl[6].exp_class = 4'd6;  tbl[6].exp_score = 8'sd8;
    tbl[7].pos_cnt[8] = 5'd10;
    tbl[7].exp_class = 4'd8;  tbl[7].exp_score = 8'sd10;

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start      = 1'($urandom);
      pos_spikes = NC'($urandom);
      neg_spikes = NC'($urandom);
      @(negedge clk);
      check("reset_busy", int'(busy), 0);
      check("reset_rv", int'(result_valid), 0);
      check("reset_class", int'(class_out), 0);
      check("reset_score", int'(score_out), 0);
    end
    reset      = 1'b0;
    start      = 1'b0;
    pos_spikes = '0;
    neg_spikes = '0;

    for (int j = 0; j < NV - 1; j++) run_vec(tbl[j]);

    // Abort during accumulation: reset sampled on window edge 8.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      pos_spikes = 10'b0000001000;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    $display("mid-window reset at cycle %0d: busy %0d class %0d score %0d",
             cyc, busy, class_out, $signed(score_out));
    check("abort_busy", int'(busy), 0);
    check("abort_rv", int'(result_valid), 0);
    check("abort_class", int'(class_out), 0);
    check("abort_score", int'(score_out), 0);
    check("abort_sat_class", int'(class_s), 0);
    reset      = 1'b0;
    pos_spikes = '0;
    repeat (LAT + 5) @(negedge clk);
    check("abort_idle", int'(busy), 0);
    run_vec(tbl[7]);

    // start held high: back-to-back runs every LAT+1 cycles, no extra results.
    @(negedge clk);
    for (int kk = 0; kk < 3; kk++) push_exp(tbl[5], cyc + 1 + LAT + kk * (LAT + 1));
    start = 1'b1;
    repeat (3 * (LAT + 1)) @(negedge clk);
    start = 1'b0;
    repeat (LAT + 5) @(negedge clk);
    check("held_start_busy", int'(busy), 0);
    check("held_start_results", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
